mem_stage: RTL and testbench

- Pipeline MEM stage between EX and WB.
- Takes the EX/MEM-registered instruction, runs the data-memory bus transaction (req/gnt/rvalid) and formats load data.
- Builds store byte-enables and registers the result into the MEM/WB pipe register that feeds the writeback stage.
- Raises a busy stall while a bus access is outstanding and publishes forwarding info.

---
 rtl/mem_stage_pkg.sv | 57 +++++
 rtl/mem_stage_align.sv | 44 ++++
 rtl/mem_stage.sv | 157 +++++++++++++++
 tb/tb_mem_stage.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage: access widths, FSM encoding and pipe-register records.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } mem_width_t;

   typedef logic [1:0] mem_fsm_t;
   localparam mem_fsm_t IDLE     = 2'd0;
   localparam mem_fsm_t WAIT_GNT = 2'd1;
   localparam mem_fsm_t WAIT_RSP = 2'd2;
   localparam mem_fsm_t DRAIN    = 2'd3;

   typedef struct packed {
      logic [31:0] alu_out;
      logic [31:0] rs2_data;
      logic        mem_read;
      logic        mem_write;
      mem_width_t  mem_width;
      logic        mem_sign;
      logic        rf_wr_en;
      logic [1:0]  rf_wr_src;
      logic [31:0] csr_out;
      logic [31:0] next_pc;
   } ex_state_t;

   typedef struct packed {
      logic [31:0] alu_out;
      logic [31:0] mem_dout;
      logic        rf_wr_en;
      logic [1:0]  rf_wr_src;
      logic [31:0] csr_out;
      logic [31:0] next_pc;
   } mem_state_t;

   typedef struct packed {
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } reg_meta_t;

   typedef struct packed {
      logic stall;
      logic squash;
   } stage_ctrl_t;

   typedef struct packed {
      logic        valid;
      logic        rf_wr_en;
      logic        mem_read;
      logic [4:0]  rd;
      logic [31:0] rd_data;
   } data_fwd_t;

endpackage

// File: rtl/mem_stage_align.sv
// Combinational load extract/extend and store byte-enable/data replication.
module mem_align
   import mem_stage_pkg::*;
(
   input  mem_width_t  width,
   input  logic        sign,
   input  logic [1:0]  off,
   input  logic [31:0] rdata,
   input  logic [31:0] st_data,
   output logic [31:0] ld_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{off, 3'b000} +: 8];
      half_sel = off[1] ? rdata[31:16] : rdata[15:0];
      ld_data  = rdata;
      st_be    = 4'b1111;
      st_wdata = st_data;
      case (width)
         BYTE: begin
            ld_data  = sign ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
            st_be    = 4'b0001 << off;
            st_wdata = {4{st_data[7:0]}};
         end
         // off[0] is ignored here; misaligned halves are trapped upstream when enabled
         HALF: begin
            ld_data  = sign ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
            st_be    = 4'b0011 << {off[1], 1'b0};
            st_wdata = {2{st_data[15:0]}};
         end
         default: begin
            ld_data  = rdata;
            st_be    = 4'b1111;
            st_wdata = st_data;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-bus req/gnt/rvalid sequencing, load/store formatting, MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN suppresses misaligned accesses and flags them on misalign_o.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        valid_i,
   input  ex_state_t   ex_state_i,
   input  reg_meta_t   reg_meta_i,
   input  stage_ctrl_t stage_ctrl_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        busy_oa,
   output logic        misalign_o,
   output logic        valid_o,
   output mem_state_t  mem_state_o,
   output reg_meta_t   reg_meta_o,
   output data_fwd_t   data_fwd_oa
);

   mem_fsm_t       state, state_next;
   logic           mem_op, misalign, acc, done, rsp, done_held;
   logic [XLEN-1:0] rdata_hold, rdata_sel;
   logic [31:0]    ld_data, st_wdata;
   logic [3:0]     st_be;
   logic           squash, stall;

   assign squash = stage_ctrl_i.squash;
   assign stall  = stage_ctrl_i.stall;
   assign mem_op = valid_i && (ex_state_i.mem_read || ex_state_i.mem_write) && !squash;

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign = mem_op &&
                     (((ex_state_i.mem_width == HALF) && ex_state_i.alu_out[0]) ||
                      ((ex_state_i.mem_width == WORD) && (ex_state_i.alu_out[1:0] != 2'b00)));
`else
   assign misalign = 1'b0;
`endif

   assign acc     = mem_op && !misalign;
   assign rsp     = (state == WAIT_RSP) && dmem_rvalid_i;
   assign done    = rsp || done_held;
   assign busy_oa = (acc && !done) || (state == DRAIN);

   always_comb begin
      state_next = state;
      dmem_req_o = 1'b0;
      case (state)
         // done_held blocks a re-issue while a completed access waits out a stall
         IDLE: begin
            dmem_req_o = acc && !done_held;
            if (acc && !done_held)
               state_next = dmem_gnt_i ? WAIT_RSP : WAIT_GNT;
         end
         WAIT_GNT: begin
            if (squash) begin
               state_next = IDLE;
            end else begin
               dmem_req_o = 1'b1;
               if (dmem_gnt_i) state_next = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            if (dmem_rvalid_i)  state_next = IDLE;
            else if (squash)    state_next = DRAIN;
         end
         DRAIN: begin
            if (dmem_rvalid_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= IDLE;
         done_held <= 1'b0;
      end else begin
         state <= state_next;
         if (squash)             done_held <= 1'b0;
         else if (rsp && stall)  done_held <= 1'b1;
         else if (!stall)        done_held <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rsp) rdata_hold <= dmem_rdata_i;
   end

   assign rdata_sel = done_held ? rdata_hold : dmem_rdata_i;

   mem_align u_align (
      .width    (ex_state_i.mem_width),
      .sign     (ex_state_i.mem_sign),
      .off      (ex_state_i.alu_out[1:0]),
      .rdata    (rdata_sel),
      .st_data  (ex_state_i.rs2_data),
      .ld_data  (ld_data),
      .st_be    (st_be),
      .st_wdata (st_wdata)
   );

   assign dmem_we_o    = ex_state_i.mem_write;
   assign dmem_addr_o  = {ex_state_i.alu_out[31:2], 2'b00};
   assign dmem_be_o    = ex_state_i.mem_write ? st_be : 4'b1111;
   assign dmem_wdata_o = st_wdata;

   // MEM/WB register: stall holds, squash/busy bubbles, otherwise advance
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o     <= 1'b0;
         mem_state_o <= '0;
         reg_meta_o  <= '0;
      end else if (!stall) begin
         if (squash || busy_oa) begin
            valid_o <= 1'b0;
         end else begin
            valid_o               <= valid_i;
            mem_state_o.alu_out   <= ex_state_i.alu_out;
            mem_state_o.mem_dout  <= (ex_state_i.mem_read && !misalign) ? ld_data : 32'h0;
            mem_state_o.rf_wr_en  <= ex_state_i.rf_wr_en && !misalign;
            mem_state_o.rf_wr_src <= ex_state_i.rf_wr_src;
            mem_state_o.csr_out   <= ex_state_i.csr_out;
            mem_state_o.next_pc   <= ex_state_i.next_pc;
            reg_meta_o            <= reg_meta_i;
         end
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)     misalign_o <= 1'b0;
      else if (!stall) misalign_o <= misalign && !busy_oa;
   end
`else
   assign misalign_o = 1'b0;
`endif

   always_comb begin
      data_fwd_oa          = '0;
      data_fwd_oa.valid    = valid_i;
      data_fwd_oa.rf_wr_en = ex_state_i.rf_wr_en;
      data_fwd_oa.mem_read = ex_state_i.mem_read;
      data_fwd_oa.rd       = reg_meta_i.rd;
      data_fwd_oa.rd_data  = ex_state_i.alu_out;
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table for formatting plus hand sequences for bus corner cases.
module tb_mem_stage;
   import mem_stage_pkg::*;

   typedef struct {
      logic        rd;
      logic        wr;
      mem_width_t  w;
      logic        sgn;
      logic [31:0] a;
      logic [31:0] rs2;
      logic [31:0] rdata;
      logic [31:0] addr_o;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] dout;
   } vec_t;

   typedef struct {
      logic [31:0] dout;
      logic [31:0] alu;
      logic        wr_en;
      logic        mis;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   ex_state_t   ex;
   reg_meta_t   meta;
   stage_ctrl_t ctrl;
   logic        req, we, gnt, rvalid, busy, misalign, valid_o;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  be;
   mem_state_t  mstate;
   reg_meta_t   meta_o;
   data_fwd_t   fwd;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   vec_t vecs[$];
   logic held = 1'b0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .valid_i       (valid),
      .ex_state_i    (ex),
      .reg_meta_i    (meta),
      .stage_ctrl_i  (ctrl),
      .dmem_req_o    (req),
      .dmem_we_o     (we),
      .dmem_addr_o   (addr),
      .dmem_be_o     (be),
      .dmem_wdata_o  (wdata),
      .dmem_gnt_i    (gnt),
      .dmem_rvalid_i (rvalid),
      .dmem_rdata_i  (rdata),
      .busy_oa       (busy),
      .misalign_o    (misalign),
      .valid_o       (valid_o),
      .mem_state_o   (mstate),
      .reg_meta_o    (meta_o),
      .data_fwd_oa   (fwd)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic r, input logic w, input mem_width_t wd, input logic s,
                         input logic [31:0] a, input logic [31:0] d);
      ex           = '0;
      ex.mem_read  = r;
      ex.mem_write = w;
      ex.mem_width = wd;
      ex.mem_sign  = s;
      ex.alu_out   = a;
      ex.rs2_data  = d;
      ex.rf_wr_en  = r;
   endtask

   function automatic vec_t mk(input logic r, input logic w, input mem_width_t wd, input logic s,
                               input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd_data,
                               input logic [31:0] ao, input logic [3:0] b, input logic [31:0] wd_o,
                               input logic [31:0] dout);
      vec_t v;
      v.rd = r; v.wr = w; v.w = wd; v.sgn = s; v.a = a; v.rs2 = d; v.rdata = rd_data;
      v.addr_o = ao; v.be = b; v.wdata = wd_o; v.dout = dout;
      return v;
   endfunction

   // Scoreboard consumer: a new MEM/WB entry appears whenever valid_o is set after an unstalled edge
   always @(negedge clk) begin
      if (rst_n === 1'b1 && valid_o === 1'b1 && !held) begin
         if (sb.size() == 0) begin
            chk("unexpected valid_o", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb mem_dout", mstate.mem_dout, e.dout);
            chk("sb alu_out", mstate.alu_out, e.alu);
            chk("sb rf_wr_en", {31'b0, mstate.rf_wr_en}, {31'b0, e.wr_en});
            chk("sb misalign_o", {31'b0, misalign}, {31'b0, e.mis});
         end
      end
      held = ctrl.stall;
   end

   task automatic apply_vec(input vec_t v);
      exp_t e;
      set_ex(v.rd, v.wr, v.w, v.sgn, v.a, v.rs2);
      valid = 1'b1; gnt = 1'b1; rvalid = 1'b0;
      @(negedge clk);
      chk("req c0", {31'b0, req}, 32'd1);
      chk("addr", addr, v.addr_o);
      chk("be", {28'b0, be}, {28'b0, v.be});
      chk("we", {31'b0, we}, {31'b0, v.wr});
      if (v.wr) chk("wdata", wdata, v.wdata);
      chk("busy c0", {31'b0, busy}, 32'd1);
      e.dout = v.dout; e.alu = v.a; e.wr_en = v.rd; e.mis = 1'b0;
      sb.push_back(e);
      tick;
      gnt = 1'b0; rvalid = 1'b1; rdata = v.rdata;
      @(negedge clk);
      chk("busy c1", {31'b0, busy}, 32'd0);
      chk("req c1", {31'b0, req}, 32'd0);
      chk("valid_o c1", {31'b0, valid_o}, 32'd0);
      tick;
      valid = 1'b0; rvalid = 1'b0; rdata = 32'h0;
      chk("valid_o c2", {31'b0, valid_o}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      exp_t e;
      rst_n = 1'b0; valid = 1'b0; ex = '0; meta = '0; ctrl = '0;
      gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;

      //             rd wr width sgn addr        rs2           rdata         addr_o       be       wdata         dout
      vecs.push_back(mk(1, 0, WORD, 0, 32'h100, 32'h0,        32'hDEADBEEF, 32'h100, 4'b1111, 32'h0,        32'hDEADBEEF));
      vecs.push_back(mk(1, 0, BYTE, 1, 32'h203, 32'h0,        32'h80123456, 32'h200, 4'b1111, 32'h0,        32'hFFFFFF80));
      vecs.push_back(mk(1, 0, BYTE, 0, 32'h203, 32'h0,        32'h80123456, 32'h200, 4'b1111, 32'h0,        32'h00000080));
      vecs.push_back(mk(1, 0, HALF, 1, 32'h202, 32'h0,        32'h80123456, 32'h200, 4'b1111, 32'h0,        32'hFFFF8012));
      vecs.push_back(mk(1, 0, HALF, 0, 32'h200, 32'h0,        32'h80123456, 32'h200, 4'b1111, 32'h0,        32'h00003456));
      vecs.push_back(mk(1, 0, BYTE, 1, 32'h201, 32'h0,        32'h12345678, 32'h200, 4'b1111, 32'h0,        32'h00000056));
      vecs.push_back(mk(0, 1, HALF, 0, 32'h102, 32'h00001234, 32'h0,        32'h100, 4'b1100, 32'h12341234, 32'h0));
      vecs.push_back(mk(0, 1, BYTE, 0, 32'h101, 32'h000000AB, 32'h0,        32'h100, 4'b0010, 32'hABABABAB, 32'h0));
      vecs.push_back(mk(0, 1, WORD, 0, 32'h104, 32'hCAFEF00D, 32'h0,        32'h104, 4'b1111, 32'hCAFEF00D, 32'h0));
`ifndef MEM_MISALIGN_TRAP_EN
      vecs.push_back(mk(1, 0, HALF, 0, 32'h203, 32'h0,        32'hA5B6C7D8, 32'h200, 4'b1111, 32'h0,        32'h0000A5B6));
      vecs.push_back(mk(1, 0, WORD, 0, 32'h102, 32'h0,        32'h01020304, 32'h100, 4'b1111, 32'h0,        32'h01020304));
      vecs.push_back(mk(0, 1, HALF, 0, 32'h103, 32'h0000BEEF, 32'h0,        32'h100, 4'b1100, 32'hBEEFBEEF, 32'h0));
`endif

      // Reset state
      tick; tick;
      @(negedge clk);
      chk("rst valid_o", {31'b0, valid_o}, 32'd0);
      chk("rst mem_state", mstate.mem_dout | mstate.alu_out, 32'h0);
      chk("rst misalign_o", {31'b0, misalign}, 32'd0);
      chk("rst req", {31'b0, req}, 32'd0);
      chk("rst busy", {31'b0, busy}, 32'd0);
      tick;
      rst_n = 1'b1;
      tick;

      foreach (vecs[i]) apply_vec(vecs[i]);

      // Grant delayed by three cycles
      tick;
      set_ex(1, 0, WORD, 0, 32'h300, 32'h0);
      valid = 1'b1; gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("wait_gnt req", {31'b0, req}, 32'd1);
         chk("wait_gnt addr", addr, 32'h300);
         chk("wait_gnt busy", {31'b0, busy}, 32'd1);
         chk("wait_gnt valid_o", {31'b0, valid_o}, 32'd0);
         tick;
      end
      gnt = 1'b1;
      @(negedge clk);
      chk("late gnt req", {31'b0, req}, 32'd1);
      e.dout = 32'h11223344; e.alu = 32'h300; e.wr_en = 1'b1; e.mis = 1'b0;
      sb.push_back(e);
      tick;
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'h11223344;
      @(negedge clk);
      chk("late gnt busy rsp", {31'b0, busy}, 32'd0);
      tick;
      valid = 1'b0; rvalid = 1'b0;
      chk("late gnt valid_o", {31'b0, valid_o}, 32'd1);

      // Squash while waiting for the response, then drain the late data
      tick;
      set_ex(1, 0, WORD, 0, 32'h400, 32'h0);
      valid = 1'b1; gnt = 1'b1;
      @(negedge clk);
      chk("sq req c0", {31'b0, req}, 32'd1);
      tick;
      gnt = 1'b0; ctrl.squash = 1'b1;
      @(negedge clk);
      chk("sq req", {31'b0, req}, 32'd0);
      tick;
      ctrl.squash = 1'b0;
      set_ex(1, 0, WORD, 0, 32'h500, 32'h0);
      @(negedge clk);
      chk("drain req", {31'b0, req}, 32'd0);
      chk("drain busy", {31'b0, busy}, 32'd1);
      chk("drain valid_o", {31'b0, valid_o}, 32'd0);
      tick;
      rvalid = 1'b1; rdata = 32'hBAD0BAD0;
      @(negedge clk);
      chk("drain rsp req", {31'b0, req}, 32'd0);
      chk("drain rsp busy", {31'b0, busy}, 32'd1);
      tick;
      rvalid = 1'b0; gnt = 1'b1;
      @(negedge clk);
      chk("post drain req", {31'b0, req}, 32'd1);
      chk("post drain addr", addr, 32'h500);
      chk("post drain valid_o", {31'b0, valid_o}, 32'd0);
      e.dout = 32'h55667788; e.alu = 32'h500; e.wr_en = 1'b1; e.mis = 1'b0;
      sb.push_back(e);
      tick;
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'h55667788;
      @(negedge clk);
      chk("post drain busy", {31'b0, busy}, 32'd0);
      tick;
      valid = 1'b0; rvalid = 1'b0;
      chk("post drain dout", mstate.mem_dout, 32'h55667788);

      // External stall across the response beat
      tick;
      set_ex(1, 0, WORD, 0, 32'h600, 32'h0);
      valid = 1'b1; gnt = 1'b1;
      @(negedge clk);
      chk("stall req c0", {31'b0, req}, 32'd1);
      e.dout = 32'h0F0F0F0F; e.alu = 32'h600; e.wr_en = 1'b1; e.mis = 1'b0;
      sb.push_back(e);
      tick;
      gnt = 1'b0; ctrl.stall = 1'b1; rvalid = 1'b1; rdata = 32'h0F0F0F0F;
      @(negedge clk);
      chk("stall rsp busy", {31'b0, busy}, 32'd0);
      tick;
      rvalid = 1'b0; rdata = 32'hFFFFFFFF;
      @(negedge clk);
      chk("stall no reissue", {31'b0, req}, 32'd0);
      chk("stall held busy", {31'b0, busy}, 32'd0);
      chk("stall valid_o", {31'b0, valid_o}, 32'd0);
      tick;
      ctrl.stall = 1'b0;
      @(negedge clk);
      chk("unstall req", {31'b0, req}, 32'd0);
      tick;
      valid = 1'b0;
      chk("stall dout", mstate.mem_dout, 32'h0F0F0F0F);

      // Non-memory instruction passes in one cycle
      tick;
      set_ex(0, 0, WORD, 0, 32'h1234, 32'h0);
      ex.rf_wr_en = 1'b1; meta.rd = 5'd5; valid = 1'b1;
      @(negedge clk);
      chk("alu busy", {31'b0, busy}, 32'd0);
      chk("alu req", {31'b0, req}, 32'd0);
      chk("fwd rd_data", fwd.rd_data, 32'h1234);
      chk("fwd rd", {27'b0, fwd.rd}, 32'd5);
      chk("fwd valid", {31'b0, fwd.valid}, 32'd1);
      e.dout = 32'h0; e.alu = 32'h1234; e.wr_en = 1'b1; e.mis = 1'b0;
      sb.push_back(e);
      tick;
      valid = 1'b0;
      chk("alu valid_o", {31'b0, valid_o}, 32'd1);
      chk("meta rd", {27'b0, meta_o.rd}, 32'd5);

`ifdef MEM_MISALIGN_TRAP_EN
      // Misaligned word load traps without a bus request
      tick;
      set_ex(1, 0, WORD, 0, 32'h101, 32'h0);
      valid = 1'b1;
      @(negedge clk);
      chk("mis req", {31'b0, req}, 32'd0);
      chk("mis busy", {31'b0, busy}, 32'd0);
      e.dout = 32'h0; e.alu = 32'h101; e.wr_en = 1'b0; e.mis = 1'b1;
      sb.push_back(e);
      tick;
      valid = 1'b0;
      chk("mis pulse", {31'b0, misalign}, 32'd1);
      chk("mis valid_o", {31'b0, valid_o}, 32'd1);
      tick;
      chk("mis pulse end", {31'b0, misalign}, 32'd0);
`endif

      // Reset in the middle of an access waiting for grant
      tick;
      set_ex(1, 0, WORD, 0, 32'h700, 32'h0);
      valid = 1'b1; gnt = 1'b0;
      @(negedge clk);
      chk("pre-rst req", {31'b0, req}, 32'd1);
      tick;
      #2 rst_n = 1'b0;
      #1 valid = 1'b0;
      #1;
      chk("mid-rst req", {31'b0, req}, 32'd0);
      chk("mid-rst busy", {31'b0, busy}, 32'd0);
      chk("mid-rst alu_out", mstate.alu_out, 32'h0);
      chk("mid-rst meta", {27'b0, meta_o.rd}, 32'd0);
      tick;
      rst_n = 1'b1;
      tick;
      apply_vec(mk(1, 0, WORD, 0, 32'h100, 32'h0, 32'h13572468, 32'h100, 4'b1111, 32'h0, 32'h13572468));

      tick; tick;
      chk("scoreboard drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
